// File: rtl/sub_pkg.sv
// ////////////////////////////////////////////////////////////////////////////
// sub_pkg : state encoding and sizing helpers for the serial ripple subtractor
// Revision: 1.0
// ////////////////////////////////////////////////////////////////////////////
`default_nettype none

package sub_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

   // One extra bit so the counter can hold WIDTH itself after the last bit.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_ripple_subtractor_half_subtractor.sv
// ////////////////////////////////////////////////////////////////////////////
// half_subtractor : one-bit x - y, difference and borrow-out
// Revision: 1.0
// ////////////////////////////////////////////////////////////////////////////
`default_nettype none

module half_subtractor (
   input  logic x,
   input  logic y,
   output logic diff,
   output logic bout
);

   assign diff = x ^ y;
   assign bout = ~x & y;

endmodule

`default_nettype wire

// File: rtl/serial_ripple_subtractor.sv
// ////////////////////////////////////////////////////////////////////////////
// serial_ripple_subtractor : bit-serial ina - inb, LSB first, registered borrow
// Revision: 1.0
// ////////////////////////////////////////////////////////////////////////////
`default_nettype none

module serial_ripple_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e           state_q,     state_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] b_q,         b_d;
   logic [WIDTH-1:0] diff_q,      diff_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic             br_q,        br_d;
   logic             borrow_q,    borrow_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic             hs0_diff, hs0_bout;
   logic             cell_diff, hs1_bout;
   logic             cell_bout;

   // Full subtractor cell: (a - b) first, then subtract the stored borrow.
   half_subtractor u_hs0 (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .diff (hs0_diff),
      .bout (hs0_bout)
   );

   half_subtractor u_hs1 (
      .x    (hs0_diff),
      .y    (br_q),
      .diff (cell_diff),
      .bout (hs1_bout)
   );

   assign cell_bout = hs0_bout | hs1_bout;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      diff_d      = diff_q;
      cnt_d       = cnt_q;
      br_d        = br_q;
      borrow_d    = borrow_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            // Operands are only looked at here, so X elsewhere never reaches state.
            if (in_valid) begin
               a_d        = ina;
               b_d        = inb;
               cnt_d      = '0;
               br_d       = 1'b0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            diff_d = {cell_diff, diff_q[WIDTH-1:1]};
            br_d   = cell_bout;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               borrow_d    = cell_bout;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         cnt_q       <= '0;
         br_q        <= 1'b0;
         borrow_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         diff_q      <= diff_d;
         cnt_q       <= cnt_d;
         br_q        <= br_d;
         borrow_q    <= borrow_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;

endmodule

`default_nettype wire
